// File: rtl/prog_loader_if.sv
// Byte-stream handshake plus instruction-memory write port for prog_loader.
// The master side is the byte source or the bench. The slave side is the loader, which drives the write port.
interface prog_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: assembles a big-endian byte frame into 16-bit words, writes them to imem, and releases the core.
// Optional trailing XOR checksum byte: define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  prog_loader_if.slave      bus,
  output logic              cpu_hold_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ADDR_W:0]   words_loaded_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_DONE, S_ERROR
`ifdef PROG_LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        rx_ready;
  logic        accept;
  logic [15:0] n_full;
  state_t      s_fin;

`ifdef PROG_LOADER_CHECKSUM_EN
  assign s_fin = S_CHK;
`else
  assign s_fin = S_DONE;
`endif

  always_comb begin
    rx_ready = 1'b0;
    case (state_q)
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO: rx_ready = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK:                                    rx_ready = 1'b1;
`endif
      default:                                  rx_ready = 1'b0;
    endcase
  end

  assign accept = bus.rx_valid && rx_ready;
  assign n_full = {len_q[15:8], bus.rx_data};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) begin
          state_d = S_LEN_HI;
          cnt_d   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_LEN_HI: if (accept) begin
        len_d[15:8] = bus.rx_data;
        state_d     = S_LEN_LO;
      end
      S_LEN_LO: if (accept) begin
        len_d[7:0] = bus.rx_data;
        if (n_full == 16'd0)                state_d = s_fin;
        else if ({16'd0, n_full} > DEPTH)   state_d = S_ERROR;
        else                                state_d = S_DATA_HI;
      end
      S_DATA_HI: if (accept) begin
        hi_d    = bus.rx_data;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d  = csum_q ^ bus.rx_data;
`endif
        state_d = S_DATA_LO;
      end
      // Address and data are captured with the low byte so that WRITE presents them directly from registers.
      S_DATA_LO: if (accept) begin
        addr_d  = cnt_q[ADDR_W-1:0];
        wdata_d = {hi_q, bus.rx_data};
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d  = csum_q ^ bus.rx_data;
`endif
        state_d = S_WRITE;
      end
      S_WRITE: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (16'(cnt_d) == len_q) ? s_fin : S_DATA_HI;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK: if (accept) begin
        state_d = (bus.rx_data == csum_q) ? S_DONE : S_ERROR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      hi_q    <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign bus.rx_ready   = rx_ready;
  assign bus.imem_we    = (state_q == S_WRITE);
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;

  assign cpu_hold_o     = (state_q != S_DONE);
  assign done_o         = (state_q == S_DONE);
  assign error_o        = (state_q == S_ERROR);
  assign busy_o         = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
  assign words_loaded_o = cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: expected imem writes are queued as frames are driven and popped by a write monitor.
module tb_prog_loader;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 256;

  logic          clk     = 1'b0;
  logic          reset   = 1'b0;
  logic          start_i = 1'b0;
  logic          cpu_hold, busy, done, error;
  logic [AW:0]   words;

  prog_loader_if #(.ADDR_W(AW)) bus ();

  prog_loader #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .start_i        (start_i),
    .bus            (bus),
    .cpu_hold_o     (cpu_hold),
    .busy_o         (busy),
    .done_o         (done),
    .error_o        (error),
    .words_loaded_o (words)
  );

  always #5 clk = ~clk;

  int               total = 0;
  int               bad   = 0;
  logic [AW+15:0]   sb[$];
  logic [15:0]      fw[$];
  logic [AW+15:0]   mon_got;
  logic [AW+15:0]   mon_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every imem write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset && bus.imem_we) begin
      mon_got = {bus.imem_addr, bus.imem_wdata};
      chk("rx_ready_in_write", {31'd0, bus.rx_ready}, 32'd0);
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_write observed=%0h expected=none", mon_got);
      end
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        chk("imem_write", 32'(mon_got), 32'(mon_exp));
      end
    end
  end

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit acc;
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    n   = 0;
    acc = 1'b0;
    do begin
      @(negedge clk);
      acc = bus.rx_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    chk("byte_accept", {31'd0, acc}, 32'd1);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  // Sends start plus a frame built from fw; nbytes<0 sends the whole frame.
  task automatic send_frame(input logic [15:0] n, input bit gaps, input bit poke,
                            input logic [7:0] csum_flip, input int nbytes);
    logic [7:0] bq[$];
    logic [7:0] cs;
    int lim;
    cs = 8'h00;
    bq.push_back(n[15:8]);
    bq.push_back(n[7:0]);
    if (n <= DEPTH) begin
      for (int i = 0; i < int'(n); i++) begin
        bq.push_back(fw[i][15:8]);
        bq.push_back(fw[i][7:0]);
        cs = cs ^ fw[i][15:8] ^ fw[i][7:0];
        sb.push_back({i[AW-1:0], fw[i]});
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      bq.push_back(cs ^ csum_flip);
`endif
    end
    pulse_start();
    lim = (nbytes < 0) ? bq.size() : nbytes;
    for (int k = 0; k < lim; k++) begin
      start_i = poke && (k + 1 < bq.size());
      send_byte(bq[k], gaps);
    end
    start_i = 1'b0;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done || error) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("end_reached", {31'd0, done | error}, 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rx_ready"}, {31'd0, bus.rx_ready}, 32'd0);
    chk({tag, "_imem_we"},  {31'd0, bus.imem_we},  32'd0);
    chk({tag, "_addr"},     32'(bus.imem_addr),     32'd0);
    chk({tag, "_wdata"},    32'(bus.imem_wdata),    32'd0);
    chk({tag, "_cpu_hold"}, {31'd0, cpu_hold},     32'd1);
    chk({tag, "_busy"},     {31'd0, busy},         32'd0);
    chk({tag, "_done"},     {31'd0, done},         32'd0);
    chk({tag, "_error"},    {31'd0, error},        32'd0);
    chk({tag, "_words"},    32'(words),            32'd0);
  endtask

  task automatic chk_done(input string tag, input int nw);
    chk({tag, "_done"},     {31'd0, done},     32'd1);
    chk({tag, "_error"},    {31'd0, error},    32'd0);
    chk({tag, "_busy"},     {31'd0, busy},     32'd0);
    chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
    chk({tag, "_words"},    32'(words),        32'(nw));
    chk({tag, "_sb_empty"}, 32'(sb.size()),    32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    #12;
    chk_reset_vals("por");
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    fw = '{16'h1234, 16'hABCD};
    send_frame(16'd2, 1'b0, 1'b0, 8'h00, -1);
    wait_end();
    chk_done("basic", 2);
    chk("basic_addr_hold",  32'(bus.imem_addr),  32'd1);
    chk("basic_wdata_hold", 32'(bus.imem_wdata), 32'hABCD);

    send_frame(16'd2, 1'b1, 1'b1, 8'h00, -1);
    wait_end();
    chk_done("gaps", 2);

    fw = {};
    send_frame(16'd0, 1'b1, 1'b0, 8'h00, -1);
    wait_end();
    chk_done("zero", 0);

    send_frame(16'd257, 1'b0, 1'b0, 8'h00, -1);
    chk("over_error",    {31'd0, error},        32'd1);
    chk("over_cpu_hold", {31'd0, cpu_hold},     32'd1);
    chk("over_busy",     {31'd0, busy},         32'd0);
    chk("over_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    chk("over_words",    32'(words),            32'd0);

    fw = '{16'h55AA};
    send_frame(16'd1, 1'b0, 1'b0, 8'h00, -1);
    wait_end();
    chk_done("recover", 1);

    fw = {};
    for (int i = 0; i < int'(DEPTH); i++) fw.push_back(16'(i * 16'h0101) ^ 16'h5A3C);
    send_frame(16'(DEPTH), 1'b0, 1'b0, 8'h00, -1);
    wait_end();
    chk_done("full_depth", int'(DEPTH));

    fw = '{16'h1234, 16'hABCD};
    send_frame(16'd2, 1'b0, 1'b0, 8'h00, 5);
    chk("mid_first_written", 32'(sb.size()), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    send_frame(16'd2, 1'b1, 1'b0, 8'h00, -1);
    wait_end();
    chk_done("after_rst", 2);

`ifdef PROG_LOADER_CHECKSUM_EN
    fw = '{16'h1234};
    send_frame(16'd1, 1'b0, 1'b0, 8'h00, -1);
    wait_end();
    chk_done("csum_ok", 1);
    send_frame(16'd1, 1'b0, 1'b0, 8'h01, -1);
    wait_end();
    chk("csum_bad_error",    {31'd0, error},    32'd1);
    chk("csum_bad_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("csum_bad_words",    32'(words),        32'd1);
    chk("csum_bad_sb_empty", 32'(sb.size()),    32'd0);
`endif

    repeat (3) @(posedge clk);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
